digit_event_streamer: RTL and testbench
=======================================

# digit_event_streamer

Converts a latched binary digit patch (p_s pixels) into a serial stream of one-hot input events for the layer-1 neuron array, one pixel event at a time in ascending index order, separated by a fixed idle gap so the neuron array, winner comparator and spike pulse logic settle between events. It sits directly upstream of layer 1 and drives its p_s-wide event input. It also carries the sample's class label alongside the stream for the supervised stage downstream.

## Interface
- p_s, 25, number of pixels / event lines (1-based indexing, bit 1 = pixel 1)
- p_gap, 4, idle cycles inserted after each event; legal range 1..255
- p_label_w, 4, label width

- i_clk  input  1  system clock, all state on rising edge
- i_rst_n  input  1  reset, asynchronous, active-low
- i_start  input  1  start request, sampled only in IDLE
- i_image  input  [p_s:1]  pixel mask, bit set = pixel active; sampled with i_start
- i_label  input  [p_label_w-1:0]  class label of the image; sampled with i_start
- o_event  output  [p_s:1]  one-hot event, high for exactly one cycle per active pixel
- o_last  output  1  high together with the final event of the image
- o_label  output  [p_label_w-1:0]  label latched at start, held until next accepted start
- o_busy  output  1  high while a stream is in progress
- o_done  output  1  one-cycle pulse when the stream completes

## Operation
- Registers: working mask [p_s:1], gap counter (8 bits), state, and all outputs; all outputs are registered.
- States: IDLE, EMIT, GAP.
- IDLE: when i_start=1, load mask<=i_image, o_label<=i_label, o_busy<=1, go EMIT. Otherwise hold.
- EMIT, mask nonzero: o_event<=lowest-index set bit of mask (one-hot); clear that bit in mask; o_last<=1 if no other bit remains; cnt<=p_gap-1; go GAP.
- EMIT, mask zero: o_done<=1, o_busy<=0, go IDLE.
- GAP: o_event<=0, o_last<=0; if cnt==0 go EMIT, else cnt<=cnt-1.
- o_done is cleared on the cycle after it is set.
- i_start while not in IDLE is ignored; i_image/i_label changes after acceptance have no effect.
- All-zero image: no events, o_done one cycle after acceptance.
- Reset (asynchronous, any state): state IDLE; mask, cnt, o_event, o_last, o_busy, o_done, o_label all 0. A stream interrupted by reset is abandoned; no o_done is produced.

## Timing
- Start accepted at edge k (IDLE, i_start=1); o_busy high from edge k.
- Event j (j=1..N, ascending pixel index) asserted at edge k+1+(j-1)(p_gap+1), low at the next edge.
- o_event is never high on two consecutive cycles; at most one bit set at any time.
- o_last coincides exactly with event N.
- o_done rises and o_busy falls at edge k+1+N(p_gap+1) (N=0: edge k+1).
- Earliest next start: accepted at the edge after o_done rises (state already IDLE during the o_done cycle).
- Stream length is data-dependent only through N, not pixel positions.

## Test plan
- Reset: assert i_rst_n=0 mid-GAP -> all outputs 0 immediately, state IDLE; after release, no event until a new start.
- p_gap=4, i_image bits {1,7,25}, label 3, start at edge k -> o_event=bit1 at k+1, bit7 at k+6, bit25 at k+11 with o_last=1; o_done at k+16; o_label=3 throughout.
- All-zero image -> no events, o_done pulse at k+1, o_busy high only during cycle k..k+1.
- All 25 bits set, p_gap=1 -> 25 events at k+1, k+3, …, k+49 in index order; o_done at k+51.
- i_start held high and i_image changed during a stream -> ignored; events match the originally latched mask; new stream starts at the edge after o_done if i_start still high.
- Back-to-back: start image {5} then image {2} immediately after o_done -> second stream's event at acceptance edge +1, label updated at that acceptance edge.

Source files
------------

// File: rtl/digit_event_streamer.sv
// Serialises a latched binary pixel mask into one-hot events, lowest index first,
// with a fixed idle gap after every event. The class label rides alongside the stream.
module digit_event_streamer #(
  parameter int p_s       = 25,
  parameter int p_gap     = 4,
  parameter int p_label_w = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [p_s:1]         i_image,
  input  logic [p_label_w-1:0] i_label,
  output logic [p_s:1]         o_event,
  output logic                 o_last,
  output logic [p_label_w-1:0] o_label,
  output logic                 o_busy,
  output logic                 o_done
);

  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_GAP} state_e;

  localparam logic [7:0]   GAP_LOAD = 8'(p_gap - 1);
  localparam logic [p_s:1] LSB      = {{(p_s-1){1'b0}}, 1'b1};

  state_e                 state_q, state_d;
  logic [p_s:1]           mask_q, mask_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [p_s:1]           event_q, event_d;
  logic                   last_q, last_d;
  logic [p_label_w-1:0]   label_q, label_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  // Two's-complement trick isolates the lowest set bit in one step.
  logic [p_s:1] low_bit, rest;
  assign low_bit = mask_q & (~mask_q + LSB);
  assign rest    = mask_q & ~low_bit;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    label_d = label_q;
    busy_d  = busy_q;
    event_d = '0;
    last_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          mask_d  = i_image;
          label_d = i_label;
          busy_d  = 1'b1;
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (|mask_q) begin
          event_d = low_bit;
          mask_d  = rest;
          last_d  = ~|rest;
          cnt_d   = GAP_LOAD;
          state_d = S_GAP;
        end else begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_GAP: begin
        if (cnt_q == 8'd0) state_d = S_EMIT;
        else               cnt_d   = cnt_q - 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      cnt_q   <= '0;
      event_q <= '0;
      last_q  <= 1'b0;
      label_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      event_q <= event_d;
      last_q  <= last_d;
      label_q <= label_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_event = event_q;
  assign o_last  = last_q;
  assign o_label = label_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;

endmodule

// File: tb/tb_digit_event_streamer.sv
// Scoreboard bench: two instances (gap 4 and gap 1); expected events and done cycles
// are queued when a start is driven and consumed by per-instance negedge monitors.
module tb_digit_event_streamer;
  localparam int S = 25, LW = 4, GA = 4, GB = 1;

  logic clk = 1'b0, rst_n = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0;
  logic [S:1] img_a = '0, img_b = '0;
  logic [LW-1:0] lbl_a = '0, lbl_b = '0;
  logic [S:1] ev_a, ev_b;
  logic last_a, last_b, busy_a, busy_b, done_a, done_b;
  logic [LW-1:0] label_a, label_b;

  digit_event_streamer #(.p_s(S), .p_gap(GA), .p_label_w(LW)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_a), .i_image(img_a), .i_label(lbl_a),
    .o_event(ev_a), .o_last(last_a), .o_label(label_a), .o_busy(busy_a), .o_done(done_a));

  digit_event_streamer #(.p_s(S), .p_gap(GB), .p_label_w(LW)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_b), .i_image(img_b), .i_label(lbl_b),
    .o_event(ev_b), .o_last(last_b), .o_label(label_b), .o_busy(busy_b), .o_done(done_b));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0, n_fail = 0;

  typedef struct { int cyc; logic [S:1] ev; logic last; } exp_t;
  exp_t q_a[$], q_b[$];
  int   dq_a[$], dq_b[$];
  exp_t e_a, e_b;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: walk pixels in ascending order, one event per gap+1 cycles.
  task automatic push(bit sel, int k, logic [S:1] img);
    int n, j, gap;
    exp_t e;
    n = 0; j = 0;
    gap = sel ? GB : GA;
    for (int i = 1; i <= S; i++) if (img[i]) n++;
    for (int i = 1; i <= S; i++) begin
      if (img[i]) begin
        j++;
        e.cyc = k + 1 + (j - 1) * (gap + 1);
        e.ev = '0;
        e.ev[i] = 1'b1;
        e.last = (j == n);
        if (sel) q_b.push_back(e); else q_a.push_back(e);
      end
    end
    if (sel) dq_b.push_back(k + 1 + n * (gap + 1));
    else     dq_a.push_back(k + 1 + n * (gap + 1));
  endtask

  always @(negedge clk) if (rst_n) begin
    if (ev_a !== '0) begin
      if (q_a.size() == 0) chk("a_unexpected_event", ev_a, 0);
      else begin
        e_a = q_a.pop_front();
        chk("a_event", ev_a, e_a.ev);
        chk("a_event_cycle", cyc, e_a.cyc);
        chk("a_last", last_a, e_a.last);
      end
    end else if (last_a) chk("a_last_without_event", last_a, 0);
    if (q_a.size() > 0 && q_a[0].cyc < cyc) begin
      chk("a_missed_event", cyc, q_a[0].cyc);
      void'(q_a.pop_front());
    end
    if (done_a) begin
      if (dq_a.size() == 0) chk("a_unexpected_done", 1, 0);
      else chk("a_done_cycle", cyc, dq_a.pop_front());
    end else if (dq_a.size() > 0 && dq_a[0] < cyc) begin
      chk("a_missed_done", cyc, dq_a[0]);
      void'(dq_a.pop_front());
    end
  end

  always @(negedge clk) if (rst_n) begin
    if (ev_b !== '0) begin
      if (q_b.size() == 0) chk("b_unexpected_event", ev_b, 0);
      else begin
        e_b = q_b.pop_front();
        chk("b_event", ev_b, e_b.ev);
        chk("b_event_cycle", cyc, e_b.cyc);
        chk("b_last", last_b, e_b.last);
      end
    end else if (last_b) chk("b_last_without_event", last_b, 0);
    if (q_b.size() > 0 && q_b[0].cyc < cyc) begin
      chk("b_missed_event", cyc, q_b[0].cyc);
      void'(q_b.pop_front());
    end
    if (done_b) begin
      if (dq_b.size() == 0) chk("b_unexpected_done", 1, 0);
      else chk("b_done_cycle", cyc, dq_b.pop_front());
    end else if (dq_b.size() > 0 && dq_b[0] < cyc) begin
      chk("b_missed_done", cyc, dq_b[0]);
      void'(dq_b.pop_front());
    end
  end

  // Called just after a falling edge; the start is taken at the next rising edge k.
  task automatic go_a(logic [S:1] img, logic [LW-1:0] lbl, bit hold, output int k);
    img_a = img; lbl_a = lbl; start_a = 1'b1;
    k = cyc + 1;
    push(1'b0, k, img);
    @(negedge clk);
    if (!hold) start_a = 1'b0;
    chk("a_busy_after_accept", busy_a, 1);
    chk("a_label_after_accept", label_a, lbl);
  endtask

  task automatic drain(int budget);
    bit empty;
    empty = 1'b0;
    for (int i = 0; i < budget && !empty; i++) begin
      @(negedge clk);
      #1 empty = (q_a.size() == 0 && dq_a.size() == 0 && q_b.size() == 0 && dq_b.size() == 0);
    end
    chk("drain_timeout", empty, 1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k, k2;
    logic [S:1] t;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_event", ev_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_label", label_a, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Pixels {1,7,25}, label 3
    t = '0; t[1] = 1'b1; t[7] = 1'b1; t[25] = 1'b1;
    go_a(t, 4'd3, 1'b0, k);
    drain(40);
    chk("t1_label_held", label_a, 3);
    chk("t1_busy_low", busy_a, 0);

    // All-zero image: done one cycle after acceptance
    go_a('0, 4'd5, 1'b0, k);
    @(negedge clk);
    chk("zero_busy_low", busy_a, 0);
    chk("zero_done", done_a, 1);
    @(negedge clk);
    chk("zero_done_cleared", done_a, 0);

    // Start held, image/label changed mid-stream: restart right after done
    t = '0; t[3] = 1'b1; t[4] = 1'b1;
    go_a(t, 4'd6, 1'b1, k);
    t = '0; t[10] = 1'b1;
    img_a = t; lbl_a = 4'd2;
    push(1'b0, k + 12, t);
    for (int i = 0; i < 100 && cyc < k + 12; i++) @(negedge clk);
    start_a = 1'b0;
    chk("held_label_new", label_a, 2);
    chk("held_busy_new", busy_a, 1);
    drain(40);

    // Back-to-back: {5} then {2} in the o_done cycle
    t = '0; t[5] = 1'b1;
    go_a(t, 4'd1, 1'b0, k);
    for (int i = 0; i < 100 && cyc < k + 6; i++) @(negedge clk);
    chk("b2b_done", done_a, 1);
    chk("b2b_label_before", label_a, 1);
    t = '0; t[2] = 1'b1;
    go_a(t, 4'd9, 1'b0, k2);
    drain(40);

    // All 25 pixels on the gap-1 instance
    img_b = '1; lbl_b = 4'd7; start_b = 1'b1;
    k = cyc + 1;
    push(1'b1, k, img_b);
    @(negedge clk);
    start_b = 1'b0;
    chk("b_busy_after_accept", busy_b, 1);
    chk("b_label_after_accept", label_b, 7);
    drain(80);
    chk("b_busy_low", busy_b, 0);

    // Reset in the middle of a gap abandons the stream
    t = '0; t[1] = 1'b1; t[7] = 1'b1;
    go_a(t, 4'd4, 1'b0, k);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_event", ev_a, 0);
    chk("midrst_last", last_a, 0);
    chk("midrst_busy", busy_a, 0);
    chk("midrst_done", done_a, 0);
    chk("midrst_label", label_a, 0);
    q_a.delete(); dq_a.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("postrst_busy", busy_a, 0);
    chk("postrst_event", ev_a, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
